// File: rtl/bf_io_uart.sv
// bfcpu I/O port responder: '.' writes feed a TX FIFO drained by an 8N1 transmitter,
// ',' reads are served from an RX FIFO filled by an 8N1 receiver, stalling until data exists.
module bf_io_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_req,
    input  logic       io_dir,
    input  logic [7:0] io_wdata,
    output logic       io_ack,
    output logic [7:0] io_rdata,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       rx_overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {H_IDLE = 2'd0, H_ACK = 2'd1, H_WAIT = 2'd2} hs_state_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_START = 2'd1, T_DATA = 2'd2, T_STOP = 2'd3} tx_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} rx_state_t;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    logic [7:0]  tx_mem_r [FIFO_DEPTH];
    logic [7:0]  rx_mem_r [FIFO_DEPTH];
    logic [AW:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
    logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic        overrun_set_s;

    hs_state_t   hs_state_r, hs_next_s;
    logic        io_ack_r;
    logic [7:0]  io_rdata_r;

    tx_state_t   tx_state_r, tx_next_s;
    logic [CW-1:0] tx_cnt_r;
    logic [2:0]  tx_idx_r;
    logic [7:0]  tx_shift_r;
    logic        uart_tx_r;
    logic        tx_bit_end_s;

    rx_state_t   rx_state_r, rx_next_s;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]  rx_idx_r;
    logic [7:0]  rx_shift_r;
    logic        rx_meta_r, rx_sync_r, rx_prev_r, rx_valid_r, rx_overrun_r;
    logic        rx_bit_end_s, rx_fall_s;

    assign tx_full_s    = ptr_full(tx_wptr_r, tx_rptr_r);
    assign tx_empty_s   = (tx_wptr_r == tx_rptr_r);
    assign rx_full_s    = ptr_full(rx_wptr_r, rx_rptr_r);
    assign rx_empty_s   = (rx_wptr_r == rx_rptr_r);
    assign tx_bit_end_s = (tx_cnt_r == BIT_LAST);
    assign rx_bit_end_s = (rx_cnt_r == BIT_LAST);
    assign rx_fall_s    = rx_prev_r & ~rx_sync_r;

    assign io_ack     = io_ack_r;
    assign io_rdata   = io_rdata_r;
    assign uart_tx    = uart_tx_r;
    assign rx_overrun = rx_overrun_r;

    // FIFO pointer bookkeeping for both directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_r <= '0;
            tx_rptr_r <= '0;
            rx_wptr_r <= '0;
            rx_rptr_r <= '0;
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + (AW+1)'(1);
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + (AW+1)'(1);
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + (AW+1)'(1);
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + (AW+1)'(1);
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wptr_r[AW-1:0]] <= io_wdata;
        if (rx_push_s) rx_mem_r[rx_wptr_r[AW-1:0]] <= rx_shift_r;
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_state_r <= H_IDLE;
        else        hs_state_r <= hs_next_s;
    end

    // Handshake next state: a held request after the ack parks in H_WAIT.
    always_comb begin
        hs_next_s = hs_state_r;
        case (hs_state_r)
            H_IDLE: begin
                if (io_req && ((io_dir && !tx_full_s) || (!io_dir && !rx_empty_s))) hs_next_s = H_ACK;
                else hs_next_s = H_IDLE;
            end
            H_ACK:  hs_next_s = H_WAIT;
            H_WAIT: begin
                if (!io_req) hs_next_s = H_IDLE;
                else         hs_next_s = H_WAIT;
            end
            default: hs_next_s = H_IDLE;
        endcase
    end

    // Handshake outputs: FIFO strobes issued on the IDLE->ACK transition.
    always_comb begin
        tx_push_s = 1'b0;
        rx_pop_s  = 1'b0;
        if (hs_state_r == H_IDLE && io_req) begin
            tx_push_s = io_dir && !tx_full_s;
            rx_pop_s  = !io_dir && !rx_empty_s;
        end else begin
            tx_push_s = 1'b0;
            rx_pop_s  = 1'b0;
        end
    end

    // Registered CPU-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_ack_r   <= 1'b0;
            io_rdata_r <= 8'h00;
        end else begin
            io_ack_r <= (hs_next_s == H_ACK);
            if (rx_pop_s) io_rdata_r <= rx_mem_r[rx_rptr_r[AW-1:0]];
        end
    end

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_r <= T_IDLE;
        else        tx_state_r <= tx_next_s;
    end

    // TX next state; a queued byte at the end of STOP starts the next frame directly.
    always_comb begin
        tx_next_s = tx_state_r;
        tx_pop_s  = 1'b0;
        case (tx_state_r)
            T_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s  = 1'b1;
                    tx_next_s = T_START;
                end else begin
                    tx_next_s = T_IDLE;
                end
            end
            T_START: begin
                if (tx_bit_end_s) tx_next_s = T_DATA;
                else              tx_next_s = T_START;
            end
            T_DATA: begin
                if (tx_bit_end_s && tx_idx_r == 3'd7) tx_next_s = T_STOP;
                else                                  tx_next_s = T_DATA;
            end
            T_STOP: begin
                if (tx_bit_end_s && !tx_empty_s) begin
                    tx_pop_s  = 1'b1;
                    tx_next_s = T_START;
                end else if (tx_bit_end_s) begin
                    tx_next_s = T_IDLE;
                end else begin
                    tx_next_s = T_STOP;
                end
            end
            default: tx_next_s = T_IDLE;
        endcase
    end

    // TX datapath: bit timer, shifter and the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_r   <= '0;
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            uart_tx_r  <= 1'b1;
        end else if (tx_pop_s) begin
            tx_shift_r <= tx_mem_r[tx_rptr_r[AW-1:0]];
            tx_cnt_r   <= '0;
            tx_idx_r   <= 3'd0;
            uart_tx_r  <= 1'b0;
        end else if (tx_state_r != T_IDLE) begin
            if (tx_bit_end_s) begin
                tx_cnt_r <= '0;
                case (tx_state_r)
                    T_START: uart_tx_r <= tx_shift_r[0];
                    T_DATA: begin
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        tx_idx_r   <= tx_idx_r + 3'd1;
                        uart_tx_r  <= (tx_idx_r == 3'd7) ? 1'b1 : tx_shift_r[1];
                    end
                    default: uart_tx_r <= 1'b1;
                endcase
            end else begin
                tx_cnt_r <= tx_cnt_r + CW'(1);
            end
        end
    end

    // RX synchronizer plus previous-sample flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_r <= R_IDLE;
        else        rx_state_r <= rx_next_s;
    end

    // RX next state; a start bit that is high again at mid-bit is rejected as a glitch.
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            R_IDLE: begin
                if (rx_fall_s) rx_next_s = R_START;
                else           rx_next_s = R_IDLE;
            end
            R_START: begin
                if (rx_cnt_r == HALF_LAST) rx_next_s = rx_sync_r ? R_IDLE : R_DATA;
                else                       rx_next_s = R_START;
            end
            R_DATA: begin
                if (rx_bit_end_s && rx_idx_r == 3'd7) rx_next_s = R_STOP;
                else                                  rx_next_s = R_DATA;
            end
            R_STOP: begin
                if (rx_bit_end_s) rx_next_s = R_IDLE;
                else              rx_next_s = R_STOP;
            end
            default: rx_next_s = R_IDLE;
        endcase
    end

    // RX datapath: mid-bit sampling, shift-in LSB first, valid strobe on a good stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_r   <= '0;
            rx_idx_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                R_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_idx_r <= 3'd0;
                end
                R_START: begin
                    if (rx_cnt_r == HALF_LAST) rx_cnt_r <= '0;
                    else                       rx_cnt_r <= rx_cnt_r + CW'(1);
                end
                R_DATA: begin
                    if (rx_bit_end_s) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_idx_r   <= rx_idx_r + 3'd1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                default: begin
                    if (rx_bit_end_s) begin
                        rx_cnt_r   <= '0;
                        rx_valid_r <= rx_sync_r;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
            endcase
        end
    end

    // RX FIFO admission: a simultaneous CPU pop makes room even when full.
    always_comb begin
        rx_push_s     = 1'b0;
        overrun_set_s = 1'b0;
        if (rx_valid_r) begin
            rx_push_s     = !rx_full_s || rx_pop_s;
            overrun_set_s = rx_full_s && !rx_pop_s;
        end else begin
            rx_push_s     = 1'b0;
            overrun_set_s = 1'b0;
        end
    end

    // Sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             rx_overrun_r <= 1'b0;
        else if (overrun_set_s) rx_overrun_r <= 1'b1;
    end

endmodule
